// File: rtl/frequency_meter.sv
// frequency_meter: counts rising edges of an asynchronous input over a
// fixed gate window and reports the count as packed BCD.
module frequency_meter #(
   parameter int GATE_CYCLES = 50000000,
   parameter int DIGITS      = 6
) (
   input  logic                CP,
   input  logic                nCR,
   input  logic                EN,
   input  logic                SIG_IN,
   output logic [4*DIGITS-1:0] FREQ,
   output logic                VALID,
   output logic                OVF,
   output logic                BUSY
);

   localparam int            CW   = $clog2(GATE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

   state_t              state, state_nxt;
   logic                s1, s2, s3;
   logic                rise;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [4*DIGITS-1:0] acc, acc_nxt, acc_inc, acc_fin;
   logic                sat, sat_nxt, sat_fin;
   logic                all9, carry, done;

   // stages reset high so releasing reset never looks like a rising edge
   always_ff @(posedge CP) begin
      if (!nCR) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= SIG_IN;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   always_comb begin
      acc_inc = acc;
      carry   = 1'b1;
      all9    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] != 4'd9)
            all9 = 1'b0;
         if (carry) begin
            if (acc[4*i +: 4] == 4'd9) begin
               acc_inc[4*i +: 4] = 4'd0;
            end else begin
               acc_inc[4*i +: 4] = acc[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   // all-9s saturates instead of wrapping; the sticky flag records it
   assign acc_fin = (rise && !all9) ? acc_inc : acc;
   assign sat_fin = sat | (rise & all9);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      acc_nxt   = '0;
      sat_nxt   = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (EN)
               state_nxt = GATE;
         end
         GATE: begin
            if (!EN) begin
               state_nxt = IDLE;
            end else if (cnt == LAST) begin
               state_nxt = LATCH;
               done      = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
               acc_nxt = acc_fin;
               sat_nxt = sat_fin;
            end
         end
         LATCH: begin
            state_nxt = EN ? GATE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CP) begin
      if (!nCR) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         sat   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         acc   <= acc_nxt;
         sat   <= sat_nxt;
      end
   end

   always_ff @(posedge CP) begin
      if (!nCR) begin
         FREQ <= '0;
         OVF  <= 1'b0;
      end else if (done) begin
         FREQ <= acc_fin;
         OVF  <= sat_fin;
      end
   end

   assign VALID = (state == LATCH);
   assign BUSY  = (state == GATE);

endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: three meter configurations share one random stimulus
// stream; each has its own reference model, result queue and monitor.
module tb_frequency_meter;

   localparam int MAXT = 12000;

   typedef struct {
      int c;
      int f;
      bit o;
   } exp_t;

   logic CP;
   logic nCR, EN, SIG_IN;

   bit sig_w [MAXT];
   bit en_w  [MAXT];
   bit rst_w [MAXT];

   int tlen      = 0;
   int pc        = 0;
   int tests     = 0;
   int fails     = 0;
   bit plan_done = 1'b0;
   bit run_done  = 1'b0;

   initial begin
      CP = 1'b1;
      forever #5 CP = ~CP;
   end

   always @(posedge CP) pc <= pc + 1;

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         if (fails <= 25)
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, req, pc - 1);
      end
   endtask

   // level of SIG_IN as seen by the meter at posedge i (reset reads high)
   function automatic bit sv(input int i);
      if (i < 0 || rst_w[i]) return 1'b1;
      return sig_w[i];
   endfunction

   // a 0->1 step between consecutive sampled levels
   function automatic bit rose(input int i);
      if (i < 0 || rst_w[i]) return 1'b0;
      return sv(i) & ~sv(i - 1);
   endfunction

   task automatic seg(input int len, input bit rst, input bit en,
                      input int per, input bit noise);
      int ph;
      ph = $urandom_range(0, 19);
      for (int i = 0; i < len; i++) begin
         rst_w[tlen] = rst;
         en_w[tlen]  = en;
         if (noise)
            sig_w[tlen] = 1'($urandom_range(0, 1));
         else if (per == 0)
            sig_w[tlen] = 1'b1;
         else
            sig_w[tlen] = (((tlen + ph) % per) < (per / 2));
         tlen++;
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int N = (g == 0) ? 100 : (g == 1) ? 400 : 300;
      localparam int D = (g == 2) ? 2 : 3;

      logic [4*D-1:0] freq;
      logic           valid, ovf, busy;
      logic [4*D-1:0] e_freq  [MAXT];
      bit             e_valid [MAXT];
      bit             e_busy  [MAXT];
      bit             e_ovf   [MAXT];
      exp_t           q[$];

      frequency_meter #(.GATE_CYCLES(N), .DIGITS(D)) dut (
         .CP    (CP),
         .nCR   (nCR),
         .EN    (EN),
         .SIG_IN(SIG_IN),
         .FREQ  (freq),
         .VALID (valid),
         .OVF   (ovf),
         .BUSY  (busy)
      );

      task automatic mark(input int c, input bit b, input bit v,
                          input logic [4*D-1:0] f, input bit o);
         e_busy[c]  = b;
         e_valid[c] = v;
         e_freq[c]  = f;
         e_ovf[c]   = o;
      endtask

      // Windows: EN seen at posedge e opens a window over posedges
      // e+1..e+N, which counts sampled rises e-1..e+N-2; the result
      // appears after posedge e+N, and posedge e+N+1 acts like idle.
      task automatic model();
         int             k, e, j, cnt, v, maxv;
         logic [4*D-1:0] hf;
         bit             ho;
         exp_t           x;
         maxv = 1;
         for (int d = 0; d < D; d++) maxv *= 10;
         maxv -= 1;
         k  = 0;
         hf = '0;
         ho = 1'b0;
         while (k < tlen) begin
            if (rst_w[k]) begin
               hf = '0;
               ho = 1'b0;
               mark(k, 1'b0, 1'b0, hf, ho);
               k++;
            end else if (!en_w[k]) begin
               mark(k, 1'b0, 1'b0, hf, ho);
               k++;
            end else begin
               e = k;
               mark(e, 1'b1, 1'b0, hf, ho);
               j = e + 1;
               k = tlen;
               while (j < tlen) begin
                  if (rst_w[j] || !en_w[j]) begin
                     k = j;
                     break;
                  end
                  if (j == e + N) begin
                     cnt = 0;
                     for (int i = e - 1; i <= e + N - 2; i++)
                        cnt += int'(rose(i));
                     ho = (cnt > maxv);
                     v  = ho ? maxv : cnt;
                     for (int d = 0; d < D; d++) begin
                        hf[4*d +: 4] = 4'(v % 10);
                        v = v / 10;
                     end
                     mark(j, 1'b0, 1'b1, hf, ho);
                     x.c = j;
                     x.f = int'(hf);
                     x.o = ho;
                     q.push_back(x);
                     k = j + 1;
                     break;
                  end
                  mark(j, 1'b1, 1'b0, hf, ho);
                  j++;
               end
            end
         end
      endtask

      initial begin
         wait (plan_done);
         model();
      end

      always @(negedge CP) begin : mon
         int   c;
         exp_t x;
         if (plan_done && pc > 0 && pc <= tlen) begin
            c = pc - 1;
            chk($sformatf("u%0d VALID", g), int'(valid), int'(e_valid[c]));
            chk($sformatf("u%0d BUSY", g), int'(busy), int'(e_busy[c]));
            chk($sformatf("u%0d FREQ", g), int'(freq), int'(e_freq[c]));
            chk($sformatf("u%0d OVF", g), int'(ovf), int'(e_ovf[c]));
            if (valid === 1'b1) begin
               chk($sformatf("u%0d result queued", g), int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  x = q.pop_front();
                  chk($sformatf("u%0d result cycle", g), c, x.c);
                  chk($sformatf("u%0d result FREQ", g), int'(freq), x.f);
                  chk($sformatf("u%0d result OVF", g), int'(ovf), int'(x.o));
               end
            end
            for (int d = 0; d < D; d++)
               chk($sformatf("u%0d acc digit %0d <= 9", g, d),
                   int'(dut.acc[4*d +: 4] <= 4'd9), 1);
         end
      end

      initial begin
         wait (run_done);
         chk($sformatf("u%0d results left over", g), q.size(), 0);
      end
   end

   initial begin
      int m;
      nCR    = 1'b0;
      EN     = 1'b0;
      SIG_IN = 1'b1;
      seg(3, 1'b1, 1'b0, 0, 1'b0);
      seg(420, 1'b0, 1'b1, 0, 1'b0);
      seg(1000, 1'b0, 1'b1, 10, 1'b0);
      seg(1300, 1'b0, 1'b1, 2, 1'b0);
      seg(1300, 1'b0, 1'b1, 4, 1'b0);
      seg(700, 1'b0, 1'b1, 10, 1'b0);
      seg(150, 1'b0, 1'b1, 10, 1'b0);
      seg(1, 1'b0, 1'b0, 10, 1'b0);
      seg(450, 1'b0, 1'b1, 10, 1'b0);
      seg(230, 1'b0, 1'b1, 10, 1'b0);
      seg(1, 1'b1, 1'b1, 10, 1'b0);
      seg(450, 1'b0, 1'b1, 10, 1'b0);
      for (int r = 0; r < 8; r++) begin
         m = $urandom_range(0, 5);
         if (m == 0)
            seg($urandom_range(1, 4), 1'b0, 1'b0, 0, 1'b0);
         else if (m == 1)
            seg($urandom_range(1, 2), 1'b1, 1'b1, 0, 1'b0);
         seg($urandom_range(150, 500), 1'b0, 1'b1,
             $urandom_range(2, 16), (m == 2));
      end
      plan_done = 1'b1;
      for (int k = 0; k < tlen; k++) begin
         @(negedge CP);
         nCR    = ~rst_w[k];
         EN     = en_w[k];
         SIG_IN = sig_w[k];
      end
      @(negedge CP);
      @(negedge CP);
      run_done = 1'b1;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
